// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and the border test for the LBP pipeline.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int BIN_N  = 256;
    localparam int LBP_W  = 8;
    localparam int ADDR_W = 14;
    localparam int ROW_W  = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR       = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // A pixel address is {row, col}; the outermost ring of the image has no valid LBP code.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] col;
        row = addr[ADDR_W-1:ROW_W];
        col = addr[ROW_W-1:0];
        return (row == ROW_W'(0)) || (row == ROW_W'(IMG_W - 1)) ||
               (col == ROW_W'(0)) || (col == ROW_W'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_sync_fifo.sv
// Small first-word-fall-through FIFO; dout shows the oldest entry whenever not empty.
module lbp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_r == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_r == (PTR_W + 1)'(0));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/lbp_histogram.sv
// 256-bin LBP code histogram kept in an external single-port SRAM, with a touched-bit
// array standing in for a clear pass, followed by an in-order valid/ready bin dump.
module lbp_histogram
    import lbp_pkg::*;
#(
    parameter int CNT_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [LBP_W-1:0]  lbp_data,
    input  logic              lbp_finish,
    output logic              mem_en,
    output logic              mem_we,
    output logic [LBP_W-1:0]  mem_addr,
    output logic [CNT_W-1:0]  mem_wdata,
    input  logic [CNT_W-1:0]  mem_rdata,
    output logic              hist_valid,
    output logic [LBP_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    input  logic              hist_ready,
    output logic              done,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LBP_W-1:0] LAST_BIN = LBP_W'(BIN_N - 1);

    state_t            state_r;
    state_t            state_next;
    logic [LBP_W-1:0]  bin_r;
    logic [BIN_N-1:0]  touched_r;
    logic              finish_prev_r;
    logic              finish_armed_r;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LBP_W-1:0]  fifo_dout;

    logic              sample_ok;
    logic              dump_start;
    logic              late;
    logic [CNT_W-1:0]  base;
    logic              saturate;
    logic [CNT_W-1:0]  wr_value;
    logic              beat_accept;

    // A sample arriving on the very cycle the dump is launched would be stranded in the
    // FIFO, so it is treated exactly like one arriving during the dump.
    assign sample_ok   = lbp_valid && !is_border(lbp_addr);
    assign dump_start  = (state_r == ST_IDLE) && fifo_empty && finish_armed_r;
    assign late        = (state_r == ST_DUMP_RD) || (state_r == ST_DUMP_OUT) ||
                         (state_r == ST_DONE) || dump_start;
    assign fifo_push   = sample_ok && !late && !fifo_full;
    assign base        = touched_r[bin_r] ? mem_rdata : {CNT_W{1'b0}};
    assign saturate    = (base == CNT_MAX);
    assign wr_value    = saturate ? base : base + CNT_W'(1);
    assign beat_accept = (state_r == ST_DUMP_OUT) && hist_valid && hist_ready;

    lbp_sync_fifo #(
        .WIDTH(LBP_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (lbp_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .dout (fifo_dout)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state logic, FIFO pop and SRAM strobes.
    always_comb begin
        state_next = state_r;
        fifo_pop   = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {LBP_W{1'b0}};
        mem_wdata  = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = ST_RD;
                end else if (finish_armed_r) begin
                    state_next = ST_DUMP_RD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RD: begin
                mem_en     = 1'b1;
                mem_addr   = bin_r;
                state_next = ST_WR;
            end
            ST_WR: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = bin_r;
                mem_wdata  = wr_value;
                state_next = ST_IDLE;
            end
            ST_DUMP_RD: begin
                mem_en     = 1'b1;
                mem_addr   = bin_r;
                state_next = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (beat_accept) begin
                    state_next = (bin_r == LAST_BIN) ? ST_DONE : ST_DUMP_RD;
                end else begin
                    state_next = ST_DUMP_OUT;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Rising edge of the finish level arms the dump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            finish_prev_r  <= 1'b0;
            finish_armed_r <= 1'b0;
        end else begin
            finish_prev_r <= lbp_finish;
            if (lbp_finish && !finish_prev_r) begin
                finish_armed_r <= 1'b1;
            end
        end
    end

    // Current bin: the popped code while counting, the dump index while dumping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_r <= {LBP_W{1'b0}};
        end else if ((state_r == ST_IDLE) && !fifo_empty) begin
            bin_r <= fifo_dout;
        end else if (dump_start) begin
            bin_r <= {LBP_W{1'b0}};
        end else if (beat_accept && (bin_r != LAST_BIN)) begin
            bin_r <= bin_r + LBP_W'(1);
        end
    end

    // Touched bits: set on first write of a bin, cleared once the bin has been delivered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            touched_r <= {BIN_N{1'b0}};
        end else if (state_r == ST_WR) begin
            touched_r[bin_r] <= 1'b1;
        end else if (beat_accept) begin
            touched_r[bin_r] <= 1'b0;
        end
    end

    // Output beat register: load once per bin, hold until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_valid <= 1'b0;
            hist_bin   <= {LBP_W{1'b0}};
            hist_count <= {CNT_W{1'b0}};
        end else if (state_r == ST_DUMP_OUT) begin
            if (!hist_valid) begin
                hist_valid <= 1'b1;
                hist_bin   <= bin_r;
                hist_count <= touched_r[bin_r] ? mem_rdata : {CNT_W{1'b0}};
            end else if (hist_ready) begin
                hist_valid <= 1'b0;
            end
        end
    end

    // Sticky status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            if ((sample_ok && (late || fifo_full)) || ((state_r == ST_WR) && saturate)) begin
                overflow <= 1'b1;
            end
            if (beat_accept && (bin_r == LAST_BIN)) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lbp_histogram.sv
// Randomized bench for lbp_histogram: a queue-and-service-time reference model predicts
// which samples are accepted, every SRAM write, the final bin counts and the flags.
module tb_lbp_histogram;

    localparam int CW    = 5;
    localparam int DEPTH = 4;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          lbp_valid;
    logic [13:0]   lbp_addr;
    logic [7:0]    lbp_data;
    logic          lbp_finish;
    logic          mem_en;
    logic          mem_we;
    logic [7:0]    mem_addr;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] mem_rdata;
    logic          hist_valid;
    logic [7:0]    hist_bin;
    logic [CW-1:0] hist_count;
    logic          hist_ready;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    lbp_histogram #(.CNT_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
        .lbp_finish(lbp_finish),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hist_valid(hist_valid), .hist_bin(hist_bin), .hist_count(hist_count),
        .hist_ready(hist_ready), .done(done), .overflow(overflow)
    );

    // SRAM with one-cycle read latency; filled with junk during reset.
    logic [CW-1:0] sram [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) sram[i] <= CW'($urandom);
        end else begin
            if (mem_en && mem_we)  sram[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference model state.
    int m_hist [256];
    int m_q [$];
    int m_svc;
    bit m_dump, m_armed, m_fprev, m_ovf;
    int exp_wr_addr [$];
    int exp_wr_data [$];

    function automatic bit on_edge(input logic [13:0] a);
        int r, c;
        r = int'(a) / 128;
        c = int'(a) % 128;
        return (r == 0) || (r == 127) || (c == 0) || (c == 127);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_hist[i] = 0;
        m_q.delete();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        m_svc = 0; m_dump = 0; m_armed = 0; m_fprev = 0; m_ovf = 0;
    endtask

    // One clock of the model: the engine takes one queued code every 3 cycles; a full
    // queue, or a dump that has begun, refuses new samples.
    task automatic model_step();
        int sz0, code;
        bit take, start;
        if (reset) begin
            model_reset();
        end else begin
            sz0   = m_q.size();
            take  = !m_dump && (m_svc == 0) && (sz0 > 0);
            start = !m_dump && (m_svc == 0) && (sz0 == 0) && m_armed;
            if (lbp_valid && !on_edge(lbp_addr)) begin
                if (m_dump || start || sz0 >= DEPTH) m_ovf = 1;
                else m_q.push_back(int'(lbp_data));
            end
            if (take) begin
                code = m_q.pop_front();
                if (m_hist[code] == MAXC) m_ovf = 1;
                else m_hist[code]++;
                exp_wr_addr.push_back(code);
                exp_wr_data.push_back(m_hist[code]);
                m_svc = 2;
            end else if (m_svc > 0) begin
                m_svc--;
            end
            if (start) m_dump = 1;
            if (lbp_finish && !m_fprev) m_armed = 1;
            m_fprev = lbp_finish;
        end
    endtask

    // Every SRAM write must match the model's next predicted update.
    int wr_a, wr_d;
    always @(negedge clk) begin
        if (!reset && mem_en && mem_we) begin
            if (exp_wr_addr.size() == 0) begin
                check("wr_spurious", 1, 0);
            end else begin
                wr_a = exp_wr_addr.pop_front();
                wr_d = exp_wr_data.pop_front();
                check("wr_addr", int'(mem_addr), wr_a);
                check("wr_data", int'(mem_wdata), wr_d);
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int code, input logic [13:0] a);
        lbp_valid = 1'b1;
        lbp_data  = 8'(code);
        lbp_addr  = a;
        tick();
        lbp_valid = 1'b0;
    endtask

    function automatic logic [13:0] interior();
        return {7'($urandom_range(1, 126)), 7'($urandom_range(1, 126))};
    endfunction

    task automatic do_reset();
        lbp_valid  = 1'b0;
        lbp_finish = 1'b0;
        hist_ready = 1'b0;
        reset      = 1'b1;
        idle(3);
        reset      = 1'b0;
    endtask

    task automatic finish_pulse();
        lbp_finish = 1'b1;
        tick();
    endtask

    // Drain the dump with random readiness; every valid cycle must show the expected beat.
    task automatic dump_run(input int pct, input int stop_at);
        int beat, cyc;
        beat = 0;
        cyc  = 0;
        check("done_early", int'(done), 0);
        while (beat < 256 && cyc < 6000 && beat != stop_at) begin
            hist_ready = ($urandom_range(0, 99) < pct);
            @(negedge clk);
            if (hist_valid) begin
                check("beat_bin", int'(hist_bin), beat);
                check("beat_cnt", int'(hist_count), m_hist[beat]);
                if (hist_ready) beat++;
            end
            tick();
            cyc++;
        end
        hist_ready = 1'b0;
        if (stop_at < 0) begin
            check("dump_beats", beat, 256);
            @(negedge clk);
            check("done_set", int'(done), 1);
            check("valid_after", int'(hist_valid), 0);
            check("mem_idle", int'(mem_en), 0);
            check("overflow_end", int'(overflow), int'(m_ovf));
            tick();
        end
    endtask

    initial begin
        int len, gap;
        logic [13:0] a;
        lbp_addr = 14'd0;
        lbp_data = 8'd0;
        do_reset();

        // Reset values.
        @(negedge clk);
        check("rst_valid", int'(hist_valid), 0);
        check("rst_bin", int'(hist_bin), 0);
        check("rst_count", int'(hist_count), 0);
        check("rst_done", int'(done), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_mem_en", int'(mem_en), 0);
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_wdata", int'(mem_wdata), 0);

        // Single interior sample plus two border samples, then a sample after done.
        send(8'h5A, {7'd1, 7'd1});
        send(8'h11, {7'd0, 7'd9});
        send(8'h12, {7'd127, 7'd4});
        idle(10);
        finish_pulse();
        dump_run(100, -1);
        check("single_ovf", int'(overflow), 0);
        send(8'h22, {7'd5, 7'd5});
        idle(3);
        @(negedge clk);
        check("late_ovf", int'(overflow), int'(m_ovf));
        check("late_ovf_set", int'(overflow), 1);
        check("done_sticky", int'(done), 1);

        // Saturation of bin 3.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            send(3, interior());
            idle(3);
            if (k == MAXC || k == MAXC + 1) begin
                idle(4);
                @(negedge clk);
                check(k == MAXC ? "sat_pre" : "sat_post", int'(overflow), int'(m_ovf));
            end
        end
        idle(10);
        finish_pulse();
        dump_run(100, -1);

        // Back-to-back burst of codes 1..6, then random bursts including border pixels.
        do_reset();
        for (int k = 1; k <= 6; k++) send(k, interior());
        idle(20);
        for (int b = 0; b < 30; b++) begin
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                a = ($urandom_range(0, 5) == 0) ? {7'd127, 7'($urandom_range(0, 127))} : interior();
                send($urandom_range(0, 255), a);
            end
            gap = $urandom_range(0, 14);
            idle(gap);
        end
        idle(20);
        finish_pulse();
        dump_run(30, -1);
        check("wr_drain", exp_wr_addr.size(), 0);

        // Reset in the middle of a dump; stale SRAM counts must stay hidden.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send($urandom_range(0, 255), interior());
            idle($urandom_range(2, 6));
        end
        idle(10);
        finish_pulse();
        dump_run(50, 100);
        #3 reset = 1'b1;
        lbp_finish = 1'b0;
        #1;
        check("arst_valid", int'(hist_valid), 0);
        check("arst_mem_en", int'(mem_en), 0);
        check("arst_ovf", int'(overflow), 0);
        check("arst_done", int'(done), 0);
        idle(2);
        reset = 1'b0;
        send(7, interior());
        idle(8);
        finish_pulse();
        dump_run(30, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
